// File: rtl/sine_gen_mc.sv
// Multi-channel recursive sine oscillator, one shared multiplier time-multiplexed over NCH channels.
// Latency: en accepted on edge E0, channel k sample strobed after edge E0+1+k; sweep period NCH+1 cycles.
// Backpressure: none downstream; en is ignored while busy, load is accepted every cycle.
module sine_gen_mc #(
    parameter  int WL  = 16,
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              en,
    input  logic              load,
    input  logic [CW-1:0]     load_idx,
    input  logic [WL-1:0]     cosW,
    input  logic [WL-1:0]     sinW,
    output logic [WL-1:0]     sine,
    output logic [CW-1:0]     sine_ch,
    output logic              sine_valid,
    output logic              busy,
    output logic [NCH-1:0]    sat
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [WL-1:0] S_MAX   = {1'b0, {(WL-1){1'b1}}};
    localparam logic [WL-1:0] S_MIN   = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] ONE     = {{(WL-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] IDX_LAST = CW'(NCH - 1);
    localparam logic [CW-1:0] IDX_ONE  = CW'(1);
    localparam int            PW      = 2 * WL + 1;

    // Sweep control
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;

    // Per-channel oscillator state
    logic [WL-1:0]  cw_q [NCH];
    logic [WL-1:0]  y1_q [NCH];
    logic [WL-1:0]  y2_q [NCH];
    logic [NCH-1:0] sat_q;

    // Output registers
    logic [WL-1:0] sine_q;
    logic [CW-1:0] sine_ch_q;
    logic          sine_valid_q;

    // Datapath
    logic          run;
    logic          last;
    logic          collide;
    logic [WL-1:0] cw_sel;
    logic [WL-1:0] y1_sel;
    logic [WL-1:0] y2_sel;
    logic [WL:0]   cw2;
    logic [PW-1:0] mul_a;
    logic [PW-1:0] mul_b;
    logic [PW-1:0] prod;
    logic [WL+1:0] m;
    logic [WL+1:0] g;
    logic          ovf;
    logic [WL-1:0] y1_upd;
    logic [WL-1:0] y2_load;
    logic          unused_prod_lsbs;

    assign run     = (state_q == ST_RUN);
    assign last    = (idx_q == IDX_LAST);
    assign collide = run && load && (load_idx == idx_q);

    assign cw_sel = cw_q[idx_q];
    assign y1_sel = y1_q[idx_q];
    assign y2_sel = y2_q[idx_q];

    // 2*cw is exact in WL+1 bits; both operands are sign-extended so the
    // truncated PW-bit product is the exact signed (WL+1)x(WL) result.
    assign cw2   = {cw_sel, 1'b0};
    assign mul_a = {{WL{cw2[WL]}}, cw2};
    assign mul_b = {{(WL+1){y1_sel[WL-1]}}, y1_sel};
    assign prod  = mul_a * mul_b;

    // Arithmetic shift right by WL-1, keeping every significant upper bit.
    assign m = prod[PW-1:WL-1];
    assign g = m - {{2{y2_sel[WL-1]}}, y2_sel};
    assign unused_prod_lsbs = ^prod[WL-2:0];

    // g fits the WL-bit range only when its top three bits agree.
    assign ovf    = !((g[WL+1] == g[WL]) && (g[WL] == g[WL-1]));
    assign y1_upd = ovf ? (g[WL+1] ? S_MIN : S_MAX) : g[WL-1:0];

    // -sinW with the single unrepresentable case clipped to the positive limit.
    assign y2_load = (sinW == S_MIN) ? S_MAX : (~sinW + ONE);

    // Next-state for the sweep: IDLE waits for en, RUN walks channels 0..NCH-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            default: begin
                if (last) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
        endcase
    end

    // Sweep state register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Channel state: a load on a channel takes priority over its update.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NCH; i++) begin
                cw_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load && (load_idx == CW'(i))) begin
                    cw_q[i]  <= cosW;
                    y1_q[i]  <= '0;
                    y2_q[i]  <= y2_load;
                    sat_q[i] <= 1'b0;
                end else if (run && (idx_q == CW'(i))) begin
                    y1_q[i] <= y1_upd;
                    y2_q[i] <= y1_sel;
                    if (ovf) begin
                        sat_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Output sample register; a colliding load shows the freshly loaded y1 of zero.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sine_q       <= '0;
            sine_ch_q    <= '0;
            sine_valid_q <= 1'b0;
        end else begin
            sine_valid_q <= run;
            if (run) begin
                sine_ch_q <= idx_q;
                sine_q    <= collide ? '0 : y1_upd;
            end
        end
    end

    assign sine       = sine_q;
    assign sine_ch    = sine_ch_q;
    assign sine_valid = sine_valid_q;
    assign busy       = run;
    assign sat        = sat_q;

endmodule

// File: tb/tb_sine_gen_mc.sv
// Directed bench for sine_gen_mc with WL=16, NCH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every expected value below is hand-derived from the recurrence.
module tb_sine_gen_mc;

    localparam int WL  = 16;
    localparam int NCH = 4;

    logic          clk;
    logic          reset_b;
    logic          en;
    logic          load;
    logic [1:0]    load_idx;
    logic [WL-1:0] cosW;
    logic [WL-1:0] sinW;
    logic [WL-1:0] sine;
    logic [1:0]    sine_ch;
    logic          sine_valid;
    logic          busy;
    logic [NCH-1:0] sat;

    int n_assert;
    int n_fail;
    logic [WL-1:0] got [NCH];

    logic [WL-1:0] exp_quarter [5] = '{16'h4000, 16'h0000, 16'hC000, 16'h0000, 16'h4000};
    logic [WL-1:0] exp_sixth   [4] = '{16'h6EDA, 16'h6EDA, 16'h0000, 16'h9126};
    logic [WL-1:0] exp_q_cont  [4] = '{16'h0000, 16'hC000, 16'h0000, 16'h4000};
    logic [WL-1:0] exp_s_cont  [2] = '{16'h9126, 16'h0000};

    sine_gen_mc #(.WL(WL), .NCH(NCH)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .en         (en),
        .load       (load),
        .load_idx   (load_idx),
        .cosW       (cosW),
        .sinW       (sinW),
        .sine       (sine),
        .sine_ch    (sine_ch),
        .sine_valid (sine_valid),
        .busy       (busy),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [WL-1:0] c, input logic [WL-1:0] s);
        load     = 1'b1;
        load_idx = ch;
        cosW     = c;
        sinW     = s;
        tick();
        load = 1'b0;
    endtask

    // One full sweep: records each channel's sample into got[] and checks ordering.
    task automatic run_sweep();
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        en  = 1'b1;
        tick();
        en  = 1'b0;
        check("sweep_busy_rise", 32'(busy), 32'd1);
        while (n < NCH && cyc < 20) begin
            tick();
            cyc++;
            if (sine_valid) begin
                check($sformatf("sweep_order_%0d", n), 32'(sine_ch), 32'(n));
                got[n] = sine;
                n++;
            end
        end
        check("sweep_strobes", 32'(n), 32'(NCH));
        check("sweep_busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_b  = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_idx = '0;
        cosW     = '0;
        sinW     = '0;

        // Reset values while reset is held
        tick();
        tick();
        check("rst_sine", 32'(sine), 32'h0);
        check("rst_sine_ch", 32'(sine_ch), 32'h0);
        check("rst_valid", 32'(sine_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sat", 32'(sat), 32'h0);
        reset_b = 1'b1;

        // No activity without en
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("idle_valid_%0d", k), 32'(sine_valid), 32'h0);
            check($sformatf("idle_busy_%0d", k), 32'(busy), 32'h0);
        end
        check("idle_sine", 32'(sine), 32'h0);

        // Quarter-rate tone on ch0
        do_load(2'd0, 16'h0000, 16'h4000);
        for (int s = 0; s < 5; s++) begin
            run_sweep();
            check($sformatf("quarter_s%0d", s), 32'(got[0]), 32'(exp_quarter[s]));
        end
        check("unloaded_ch1_zero", 32'(got[1]), 32'h0);

        // Sixth-rate tone on ch1; ch0 keeps running independently
        do_load(2'd1, 16'h4000, 16'h6EDA);
        for (int s = 0; s < 4; s++) begin
            run_sweep();
            check($sformatf("sixth_s%0d", s), 32'(got[1]), 32'(exp_sixth[s]));
            check($sformatf("quarter_cont_s%0d", s), 32'(got[0]), 32'(exp_q_cont[s]));
        end

        // Saturation on ch2
        do_load(2'd2, 16'h7FFF, 16'h7FFF);
        run_sweep();
        check("sat_s0", 32'(got[2]), 32'h7FFF);
        check("sat_flag_s0", 32'(sat), 32'h0);
        check("sixth_cont_s0", 32'(got[1]), 32'(exp_s_cont[0]));
        run_sweep();
        check("sat_s1", 32'(got[2]), 32'h7FFF);
        check("sat_flag_s1", 32'(sat), 32'h4);
        check("sixth_cont_s1", 32'(got[1]), 32'(exp_s_cont[1]));
        do_load(2'd2, 16'h7FFF, 16'h7FFF);
        check("sat_reload_clear", 32'(sat), 32'h0);

        // en held high: a sweep every NCH+1 cycles
        en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("hold_busy_%0d", k), 32'(busy), (k % 5 != 4) ? 32'd1 : 32'd0);
            check($sformatf("hold_valid_%0d", k), 32'(sine_valid), (k % 5 != 0) ? 32'd1 : 32'd0);
            if (k % 5 != 0) begin
                check($sformatf("hold_ch_%0d", k), 32'(sine_ch), 32'((k % 5) - 1));
            end
        end
        en = 1'b0;

        // Collision on ch1 plus a non-disturbing load of ch3 mid-sweep
        en = 1'b1;
        tick();
        en       = 1'b0;
        load     = 1'b1;
        load_idx = 2'd3;
        cosW     = 16'h0000;
        sinW     = 16'h4000;
        tick();
        check("col_ch0_valid", 32'(sine_valid), 32'd1);
        check("col_ch0_idx", 32'(sine_ch), 32'd0);
        load_idx = 2'd1;
        cosW     = 16'h4000;
        sinW     = 16'h6EDA;
        tick();
        load = 1'b0;
        check("col_valid", 32'(sine_valid), 32'd1);
        check("col_idx", 32'(sine_ch), 32'd1);
        check("col_sine", 32'(sine), 32'h0);
        check("col_sat1", 32'(sat[1]), 32'd0);
        tick();
        check("col_ch2_idx", 32'(sine_ch), 32'd2);
        tick();
        check("col_ch3_idx", 32'(sine_ch), 32'd3);
        check("col_ch3_sine", 32'(sine), 32'h4000);
        check("col_busy_fall", 32'(busy), 32'd0);
        run_sweep();
        check("col_next_ch1", 32'(got[1]), 32'h6EDA);
        check("col_next_ch3", 32'(got[3]), 32'h0000);

        // Reset mid-sweep with a sticky flag set
        do_load(2'd2, 16'h7FFF, 16'h7FFF);
        run_sweep();
        run_sweep();
        check("pre_rst_sat", 32'(sat), 32'h4);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("pre_rst_valid", 32'(sine_valid), 32'd1);
        reset_b = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(sine_valid), 32'd0);
        check("midrst_sine", 32'(sine), 32'h0);
        check("midrst_sat", 32'(sat), 32'h0);
        tick();
        tick();
        reset_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("postrst_valid_%0d", k), 32'(sine_valid), 32'd0);
        end
        run_sweep();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("postrst_ch%0d", c), 32'(got[c]), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_gen_mc.md
Name: sine_gen_mc

Overview:
- Multi-channel recursive sine oscillator: y[n] = 2·cosW·y[n-1] − y[n-2], per-channel frequency and state.
- Successor to the single-channel generator. Time-multiplexes one multiplier across NCH channels, one channel per cycle.
- Adds exact-width intermediate arithmetic, per-channel load and sticky saturation flags.
- Feeds the scan-chain test-signal mux; each channel output is tagged with its index.

Parameters:
- WL, 16, sample and coefficient word length, signed fixed point s0.(WL-1).
- NCH, 4, number of channels, ≥ 2.
- CW, $clog2(NCH), channel index width; derived, do not override.

Ports:
- clk  in  1  clock.
- reset_b  in  1  asynchronous, active-low reset.
- en  in  1  sweep request: advances every channel by one sample.
- load  in  1  load request for channel load_idx.
- load_idx  in  CW  channel to load.
- cosW  in  WL  cos(ω) for the loaded channel, s0.(WL-1).
- sinW  in  WL  sin(ω) for the loaded channel, s0.(WL-1).
- sine  out  WL  latest computed sample, s0.(WL-1).
- sine_ch  out  CW  channel index of sine.
- sine_valid  out  1  one-cycle strobe: sine/sine_ch are new.
- busy  out  1  sweep in progress.
- sat  out  NCH  sticky per-channel saturation flags.

Behaviour:
- Per-channel state: cw[i] (WL), y1[i] (WL), y2[i] (WL).
- Reset (async): all cw/y1/y2 = 0, sine = 0, sine_ch = 0, sine_valid = 0, busy = 0, sat = 0, sweep index = 0.
- Load (any cycle, including mid-sweep), for channel k = load_idx:
  - cw[k] <= cosW, y1[k] <= 0, sat[k] <= 0.
  - y2[k] <= −sinW, saturated: sinW = 0x8000 (WL=16) gives 0x7FFF.
- Sweep FSM, states IDLE and RUN:
  - IDLE: on an edge with en = 1, go to RUN with idx = 0; busy = 1 from that edge. en is ignored while busy = 1, including the edge where busy falls.
  - RUN: each edge processes channel idx. It updates y1/y2 and registers sine = new y1[idx], sine_ch = idx, sine_valid = 1 for that cycle only.
  - After idx = NCH−1 is processed, return to IDLE and clear busy on the same edge.
- Timing:
  - First sine_valid is 1 cycle after busy rises; NCH consecutive valid strobes, channels in order 0..NCH−1.
  - Minimum en-to-en accepted period is NCH+1 cycles.
- Arithmetic per update:
  - Product p = 2·cw·y1, computed exactly.
  - m = floor(p / 2^(WL-1)) = arithmetic right shift, held in WL+2 bits, no truncation of upper bits.
  - g = m − sign-extended y2, in WL+2 bits.
  - If g exceeds the WL-bit signed range, y1 <= 0x7FFF or 0x8000 (WL-generic) and sat[idx] <= 1. Otherwise y1 <= g[WL-1:0].
  - y2 <= old y1.
- Load and update hitting the same channel on the same edge:
  - Load wins and the update is discarded.
  - sine_valid still pulses, with sine = 0 (post-load y1) and sat[idx] = 0.
- Load of a channel not currently being processed does not disturb the sweep.
- Reset mid-sweep aborts the sweep: busy = 0, no further sine_valid.
- Only one multiplier instance (WL+1 × WL signed).

Test Plan:
- Reset → all outputs 0. Check during reset and after release; no sine_valid without en.
- Quarter-rate tone: load ch0 with cosW = 0x0000, sinW = 0x4000, then 5 sweeps → ch0 samples 0x4000, 0x0000, 0xC000, 0x0000, 0x4000.
- Sixth-rate tone: load ch1 with cosW = 0x4000, sinW = 0x6EDA, then 4 sweeps → ch1 samples 0x6EDA, 0x6EDA, 0x0000, 0x9126.
- Saturation: load ch2 with cosW = 0x7FFF, sinW = 0x7FFF, then 2 sweeps.
  - Samples are 0x7FFF, then 0x7FFF (raw 65532 clipped).
  - sat[2] = 1 after sweep 2; reload ch2 → sat[2] = 0.
- Sequencing with NCH = 4: en pulse → busy high 4 cycles; sine_ch = 0, 1, 2, 3 on consecutive cycles; en held high throughout gives sweeps every 5 cycles.
- Collision: load ch1 on the edge that processes ch1 → ch1 output 0, next sweep matches a fresh load; assert reset mid-sweep → busy = 0 immediately, state zeroed.
